// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: datapath widths, op encodings,
// FSM state encoding and a reserved-op helper.
package shift_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ROL = 3'b000,
        OP_SLL = 3'b001,
        OP_SRA = 3'b010,
        OP_SRL = 3'b011
    } shift_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Ops 100-111 carry no shift meaning; the operand passes through.
    function automatic logic is_reserved(input logic [OP_W-1:0] op);
        return op[OP_W-1];
    endfunction

endpackage

// File: rtl/shift_arbiter_barrel.sv
// 16-bit four-stage barrel shifter. Stage k moves the data by 2**k when
// cnt[k] is set, so any count 0..15 takes exactly four mux levels.
// Unknown op codes leave the data untouched.
module shift_arbiter_barrel
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [CNT_W-1:0]  cnt,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] data_out
);

    logic [CNT_W:0][DATA_W-1:0] stage;

    assign stage[0] = data_in;

    for (genvar k = 0; k < CNT_W; k++) begin : g_stage
        localparam int S = 1 << k;
        logic [DATA_W-1:0] moved;

        // Candidate result of this stage for the selected op.
        always_comb begin
            moved = stage[k];
            case (op)
                OP_ROL:  moved = {stage[k][DATA_W-1-S:0], stage[k][DATA_W-1:DATA_W-S]};
                OP_SLL:  moved = {stage[k][DATA_W-1-S:0], {S{1'b0}}};
                OP_SRA:  moved = {{S{stage[k][DATA_W-1]}}, stage[k][DATA_W-1:S]};
                OP_SRL:  moved = {{S{1'b0}}, stage[k][DATA_W-1:S]};
                default: moved = stage[k];
            endcase
        end

        assign stage[k+1] = cnt[k] ? moved : stage[k];
    end

    assign data_out = stage[CNT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester shift unit: arbitrates between requesters, registers the
// winner's operands and presents the shifted result one cycle later.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. On the request side req_ready is a combinational one-hot grant
// that depends on req_valid; on the response side rsp_valid never depends on
// rsp_ready, and rsp_data/rsp_id/rsp_err hold steady while rsp_valid is high
// and rsp_ready is low.
//
// Build option: define SHIFT_ARB_ROUND_ROBIN_EN for round-robin tie breaking
// (pointer flips away from each granted requester); leave it undefined for
// fixed priority with requester 0 winning ties.
module shift_arbiter
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_in0,
    input  logic [DATA_W-1:0] req_in1,
    input  logic [CNT_W-1:0]  req_cnt0,
    input  logic [CNT_W-1:0]  req_cnt1,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [OP_W-1:0]   req_op1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_err,
    output state_e            dbg_state
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] opnd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OP_W-1:0]   op_q;
    logic              id_q;

    logic              rsp_fire;
    logic              can_accept;
    logic              accept;
    logic              grant_id;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    logic              rr_ptr_q;

    // Round-robin pointer: after each grant the other requester is preferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else if (accept) begin
            rr_ptr_q <= ~grant_id;
        end
    end

    // Ties go to the pointer's requester; a lone requester always wins.
    always_comb begin
        grant_id = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid.
    always_comb begin
        grant_id = ~req_valid[0];
    end
`endif

    // Accept when the holding slot is free or is being drained this cycle.
    always_comb begin
        rsp_valid  = (state_q == ST_HOLD);
        rsp_fire   = rsp_valid && rsp_ready;
        can_accept = !rst && ((state_q == ST_IDLE) || rsp_fire);
        accept     = can_accept && (|req_valid);
        req_ready  = 2'b00;
        if (accept) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    // Next state: a new accept keeps HOLD, a bare drain returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_HOLD;
        end else if (rsp_fire) begin
            state_d = ST_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand registers load only on accept, so they stay put under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            opnd_q <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
            id_q   <= 1'b0;
        end else if (accept) begin
            opnd_q <= grant_id ? req_in1  : req_in0;
            cnt_q  <= grant_id ? req_cnt1 : req_cnt0;
            op_q   <= grant_id ? req_op1  : req_op0;
            id_q   <= grant_id;
        end
    end

    shift_arbiter_barrel u_barrel (
        .data_in  (opnd_q),
        .cnt      (cnt_q),
        .op       (op_q),
        .data_out (rsp_data)
    );

    // Response sidebands come straight from the held registers.
    always_comb begin
        rsp_id    = id_q;
        rsp_err   = is_reserved(op_q);
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter. The driver pushes the hand-computed
// response for each grant it expects; a negedge monitor pops and compares
// on every response handshake.
module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int RSP_W = DATA_W + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_in0 = '0, req_in1 = '0;
    logic [CNT_W-1:0]  req_cnt0 = '0, req_cnt1 = '0;
    logic [OP_W-1:0]   req_op0 = '0, req_op1 = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_id;
    logic              rsp_err;
    state_e            dbg_state;

    int checks = 0;
    int errors = 0;
    logic [RSP_W-1:0] exp_q[$];
    logic [RSP_W-1:0] mon_exp;

    shift_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in0   (req_in0),
        .req_in1   (req_in1),
        .req_cnt0  (req_cnt0),
        .req_cnt1  (req_cnt1),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RSP_W-1:0] rsp(input logic id, input logic err, input logic [DATA_W-1:0] d);
        return {id, err, d};
    endfunction

    // Monitor: compare every response handshake against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got %0h expected none", {rsp_id, rsp_err, rsp_data});
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp", 32'({rsp_id, rsp_err, rsp_data}), 32'(mon_exp));
            end
        end
    end

    task automatic set_req0(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] c, input logic [OP_W-1:0] o);
        req_in0 = d; req_cnt0 = c; req_op0 = o;
    endtask

    task automatic set_req1(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] c, input logic [OP_W-1:0] o);
        req_in1 = d; req_cnt1 = c; req_op1 = o;
    endtask

    // One cycle of stimulus; checks the grant and queues the expected result.
    task automatic step(input string name, input logic [1:0] vld, input logic rrdy,
                        input logic [1:0] exp_rdy, input logic [RSP_W-1:0] exp_word);
        req_valid = vld;
        rsp_ready = rrdy;
        @(negedge clk);
        check(name, 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != 2'b00) exp_q.push_back(exp_word);
        @(posedge clk); #1;
    endtask

    // One backpressured cycle: result must be held and no grant given.
    task automatic hold_check(input logic [1:0] vld, input logic [DATA_W-1:0] d, input logic id);
        req_valid = vld;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("hold_req_ready", 32'(req_ready), 32'(2'b00));
        check("hold_rsp_valid", 32'(rsp_valid), 32'(1'b1));
        check("hold_rsp_data", 32'(rsp_data), 32'(d));
        check("hold_rsp_id", 32'(rsp_id), 32'(id));
        @(posedge clk); #1;
    endtask

    // One reset cycle with both requesters pending, then post-reset checks.
    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'(2'b00));
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        check("rst_rsp_data", 32'(rsp_data), 32'(16'h0000));
        check("rst_rsp_id", 32'(rsp_id), 32'(1'b0));
        check("rst_rsp_err", 32'(rsp_err), 32'(1'b0));
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
    endtask

    // Driver
    initial begin
        logic gid;
        do_reset();

        // Single request, then a back-to-back op sweep across both requesters.
        set_req0(16'h8001, 4'd1, OP_ROL);
        step("rol1", 2'b01, 1'b1, 2'b01, rsp(1'b0, 1'b0, 16'h0003));
        set_req1(16'h00F0, 4'd4, OP_SLL);
        set_req0(16'hFFFF, 4'd7, 3'b101);
        step("sll4", 2'b10, 1'b1, 2'b10, rsp(1'b1, 1'b0, 16'h0F00));
        set_req0(16'h8000, 4'd15, OP_SRA);
        step("sra15", 2'b01, 1'b1, 2'b01, rsp(1'b0, 1'b0, 16'hFFFF));
        set_req1(16'h8000, 4'd15, OP_SRL);
        step("srl15", 2'b10, 1'b1, 2'b10, rsp(1'b1, 1'b0, 16'h0001));
        set_req0(16'h1234, 4'd3, 3'b101);
        step("rsv101", 2'b01, 1'b1, 2'b01, rsp(1'b0, 1'b1, 16'h1234));
        set_req1(16'h1234, 4'd4, OP_ROL);
        step("rol4", 2'b10, 1'b1, 2'b10, rsp(1'b1, 1'b0, 16'h2341));
        set_req0(16'h4000, 4'd2, OP_SRA);
        step("sra_pos", 2'b01, 1'b1, 2'b01, rsp(1'b0, 1'b0, 16'h1000));
        set_req1(16'hF000, 4'd0, OP_SRL);
        step("cnt0", 2'b10, 1'b1, 2'b10, rsp(1'b1, 1'b0, 16'hF000));
        set_req0(16'hABCD, 4'd9, 3'b111);
        step("rsv111", 2'b01, 1'b1, 2'b01, rsp(1'b0, 1'b1, 16'hABCD));
        step("drain1", 2'b00, 1'b1, 2'b00, '0);

        // Continuous ties from a fresh reset.
        do_reset();
        set_req0(16'h0001, 4'd1, OP_SLL);
        set_req1(16'h0010, 4'd1, OP_SRL);
        for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
            gid = i[0];
`else
            gid = 1'b0;
`endif
            step("tie", 2'b11, 1'b1, gid ? 2'b10 : 2'b01,
                 rsp(gid, 1'b0, gid ? 16'h0008 : 16'h0002));
        end
        step("drain2", 2'b00, 1'b1, 2'b00, '0);

        // Backpressure for three cycles, then release with requester 1 waiting.
        set_req0(16'h00F0, 4'd4, OP_SLL);
        step("bp_acc", 2'b01, 1'b1, 2'b01, rsp(1'b0, 1'b0, 16'h0F00));
        set_req1(16'h0003, 4'd2, OP_SLL);
        for (int i = 0; i < 3; i++) hold_check(2'b10, 16'h0F00, 1'b0);
        step("bp_rel", 2'b10, 1'b1, 2'b10, rsp(1'b1, 1'b0, 16'h000C));
        step("drain3", 2'b00, 1'b1, 2'b00, '0);

        // Reset while a result is held: it is dropped and requester 0 wins next tie.
        set_req0(16'h5555, 4'd1, OP_SLL);
        step("mh_acc", 2'b01, 1'b0, 2'b01, rsp(1'b0, 1'b0, 16'hAAAA));
        hold_check(2'b00, 16'hAAAA, 1'b0);
        do_reset();
        set_req0(16'h0001, 4'd1, OP_SLL);
        set_req1(16'h0010, 4'd1, OP_SRL);
        step("mh_tie", 2'b11, 1'b1, 2'b01, rsp(1'b0, 1'b0, 16'h0002));
        step("drain4", 2'b00, 1'b1, 2'b00, '0);
        step("drain5", 2'b00, 1'b1, 2'b00, '0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous active-high reset.
REQ-003 SHALL have ports: req_valid  input  2  per-requester request valid, bit i = requester i.
REQ-004 SHALL have ports: req_ready  output  2  per-requester accept, at most one bit high.
REQ-005 SHALL have ports: req_in0, req_in1  input  16 each  operand per requester.
REQ-006 SHALL have ports: req_cnt0, req_cnt1  input  4 each  shift count per requester.
REQ-007 SHALL have ports: req_op0, req_op1  input  3 each  shift op per requester.
REQ-008 SHALL have ports: rsp_valid  output  1  result valid.
REQ-009 SHALL have ports: rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports: rsp_data  output  16  shifted result.
REQ-011 SHALL have ports: rsp_id  output  1  requester that owns rsp_data.
REQ-012 SHALL have ports: rsp_err  output  1  held op was reserved.

Function
REQ-013 SHALL run FSM states IDLE (no held operation) and HOLD (operands registered, result presented).
REQ-014 SHALL accept a request in a cycle when (state==IDLE or (rsp_valid and rsp_ready)) and at least one req_valid is high; req_ready is high only for the granted requester, combinationally, in that cycle.
REQ-015 SHALL, on accept, register operand, count, op and id, and enter HOLD next cycle; latency accept-to-rsp_valid is exactly 1 cycle.
REQ-016 SHALL drive rsp_valid high in HOLD only; rsp_data, rsp_id and rsp_err remain stable while rsp_valid and not rsp_ready.
REQ-017 SHALL compute rsp_data through one shifter on the registered operands: op 000 rotate left, 001 shift left logical, 010 shift right arithmetic, 011 shift right logical; count 0 returns the operand unchanged.
REQ-018 SHALL treat ops 100-111 as reserved: rsp_data = operand unchanged, rsp_err=1.
REQ-019 SHALL, on rsp handshake with no request accepted the same cycle, return to IDLE; with a request accepted the same cycle, remain in HOLD with new contents (throughput 1 op/cycle).
REQ-020 SHALL not change state or registers when rsp_valid and not rsp_ready; req_ready stays 0 then.
REQ-021 SHALL arbitrate, when both req_valid bits are high, per the Configuration section; a single valid requester is always granted.
REQ-022 SHALL ignore req_in/cnt/op of a requester whose req_valid is low.

Reset
REQ-023 SHALL, on rst high at a clock edge, force IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, round-robin pointer=0 (requester 0 preferred).
REQ-024 SHALL hold req_ready=0 while rst is high; a held result is discarded on reset mid-operation.

Configuration
REQ-025 SHALL use macro SHIFT_ARB_ROUND_ROBIN_EN: defined -> round-robin, pointer flips to the other requester after every grant and the pointer's requester wins ties; undefined -> fixed priority, requester 0 always wins ties, no pointer register.

Structure
REQ-026 SHALL place op encodings (ROL, SLL, SRA, SRL), data width 16 and count width 4 in shared package shift_pkg.
REQ-027 SHALL instantiate the existing 16-bit four-stage barrel shifter as its single sub-module; no other datapath duplication.

Verification
REQ-028 Single req0: in=16'h8001, cnt=1, op=000 -> req_ready[0] same cycle, next cycle rsp_valid=1, rsp_data=16'h0003, rsp_id=0.
REQ-029 Ops sweep: 16'h00F0 cnt 4 op 001 -> 16'h0F00; 16'h8000 cnt 15 op 010 -> 16'hFFFF; 16'h8000 cnt 15 op 011 -> 16'h0001; op 101 -> operand unchanged, rsp_err=1.
REQ-030 Both valid continuously, rsp_ready=1: round-robin build -> grants alternate 0,1,0,1 one per cycle; fixed build -> requester 0 every cycle, requester 1 starved.
REQ-031 Backpressure: rsp_ready=0 for 3 cycles in HOLD -> rsp_data/rsp_id stable, req_ready=0; rsp_ready=1 with req1 valid -> req_ready[1] same cycle, new result next cycle.
REQ-032 Reset mid-HOLD: rst high one cycle -> rsp_valid=0, rsp_data=0 next cycle, state IDLE, next tie granted to requester 0.
